// File: rtl/reg_file_arbiter_if.sv
// reg_file_arbiter_if: requester bus and register-file port bundle shared by the arbiter
interface reg_file_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_rs1;
    logic [NUM_REQ*ADDR_W-1:0] req_rs2;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        grant;
    logic [2:0]                owner_id;
    logic                      busy;
    logic [DATA_W-1:0]         rdata1;
    logic [DATA_W-1:0]         rdata2;
    logic [ADDR_W-1:0]         rf_rs1;
    logic [ADDR_W-1:0]         rf_rs2;
    logic [ADDR_W-1:0]         rf_rd;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      rf_we;
    logic [DATA_W-1:0]         rf_rdata1;
    logic [DATA_W-1:0]         rf_rdata2;

    modport master (
        output req, req_rs1, req_rs2, req_rd, req_wdata, req_we, rf_rdata1, rf_rdata2,
        input  grant, owner_id, busy, rdata1, rdata2, rf_rs1, rf_rs2, rf_rd, rf_wdata, rf_we
    );

    modport slave (
        input  req, req_rs1, req_rs2, req_rd, req_wdata, req_we, rf_rdata1, rf_rdata2,
        output grant, owner_id, busy, rdata1, rdata2, rf_rs1, rf_rs2, rf_rd, rf_wdata, rf_we
    );
endinterface

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: round-robin owner arbitration of the shared register file with hold limit
module reg_file_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input logic clk,
    input logic rst,
    reg_file_arbiter_if.slave bus
);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    last_owner;
    logic [2:0]    pick;
    int            best;
    int            rank;
    logic          own_req;
    logic          others;
    logic          at_max;
    logic          do_grant;

    assign own_req  = |(bus.req & bus.grant);
    assign others   = |(bus.req & ~bus.grant);
    assign at_max   = hold_cnt == HW'(MAX_HOLD - 1);
    assign do_grant = others && (state == IDLE || !own_req || at_max);
    assign bus.rdata1 = bus.rf_rdata1;
    assign bus.rdata2 = bus.rf_rdata2;

    // Pick the requester closest after last_owner in circular order
    always_comb begin
        pick = '0;
        best = NUM_REQ;
        rank = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i + NUM_REQ - 1 - int'(last_owner)) % NUM_REQ;
            if (bus.req[i] && rank < best) begin
                best = rank;
                pick = 3'(i);
            end
        end
    end

    // Route the owner's addresses and write onto the register file; write needs the owner's live request
    always_comb begin
        bus.rf_rs1   = '0;
        bus.rf_rs2   = '0;
        bus.rf_rd    = '0;
        bus.rf_wdata = '0;
        bus.rf_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.grant[i]) begin
                bus.rf_rs1   = bus.req_rs1[i*ADDR_W +: ADDR_W];
                bus.rf_rs2   = bus.req_rs2[i*ADDR_W +: ADDR_W];
                bus.rf_rd    = bus.req_rd[i*ADDR_W +: ADDR_W];
                bus.rf_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                bus.rf_we    = bus.req[i] & bus.req_we[i];
            end
        end
    end

    // Ownership FSM: grant on pick, hand over on release or hold expiry, otherwise keep the lock
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.grant    <= '0;
            bus.busy     <= 1'b0;
            bus.owner_id <= '0;
            hold_cnt     <= '0;
            last_owner   <= 3'(NUM_REQ - 1);
        end else if (do_grant) begin
            state        <= OWNED;
            bus.grant    <= NUM_REQ'(1) << pick;
            bus.busy     <= 1'b1;
            bus.owner_id <= pick;
            last_owner   <= pick;
            hold_cnt     <= '0;
        end else if (state == OWNED && !own_req) begin
            state     <= IDLE;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            hold_cnt  <= '0;
        end else if (state == OWNED) begin
            hold_cnt <= at_max ? hold_cnt : hold_cnt + HW'(1);
        end
    end
endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: scoreboard bench with a behavioural ownership model and register file
module tb_reg_file_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   miss = 0;

    logic [DATA_W-1:0]        regs [32] = '{default: '0};
    logic [ADDR_W+DATA_W-1:0] wq [$];
    int                       gq [$];
    int                       m_owner = -1;
    int                       m_last = NUM_REQ - 1;
    int                       m_held = 0;
    int                       m_nxt;
    int                       len [NUM_REQ] = '{default: 0};
    logic [NUM_REQ-1:0]       prev_g = '0;
    logic [NUM_REQ-1:0]       exp_g;
    logic                     c_we;
    logic [ADDR_W+DATA_W-1:0] c_w;
    int                       e;

    reg_file_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_file_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.rf_rdata1 = regs[bus.rf_rs1];
    assign bus.rf_rdata2 = regs[bus.rf_rs2];

    always @(posedge clk) if (bus.rf_we) regs[bus.rf_rd] <= bus.rf_wdata;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic fail(input string n);
        vec++;
        miss++;
        $display("FAIL %s at %0t", n, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int i, input logic we, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.req_we[i] = we;
        bus.req_rd[i*ADDR_W +: ADDR_W] = rd;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // Reference ownership model: commits the owner's write, then applies release / hold-limit / round-robin rules
    always @(posedge clk) begin
        if (m_owner >= 0 && bus.req[m_owner] && bus.req_we[m_owner])
            wq.push_back({bus.req_rd[m_owner*ADDR_W +: ADDR_W], bus.req_wdata[m_owner*DATA_W +: DATA_W]});
        if (rst) begin
            m_owner = -1;
            m_last  = NUM_REQ - 1;
            m_held  = 0;
        end else begin
            m_nxt = -1;
            for (int k = 1; k <= NUM_REQ; k++)
                if (m_nxt < 0 && (m_last + k) % NUM_REQ != m_owner && bus.req[(m_last + k) % NUM_REQ])
                    m_nxt = (m_last + k) % NUM_REQ;
            if (m_owner >= 0 && bus.req[m_owner] && (m_held < MAX_HOLD || m_nxt < 0)) begin
                m_held++;
            end else if (m_nxt >= 0) begin
                m_owner = m_nxt;
                m_last  = m_nxt;
                m_held  = 1;
                gq.push_back(m_nxt);
            end else begin
                m_owner = -1;
            end
        end
    end

    // Write monitor: every register-file write must match the next expected commit
    always @(posedge clk) begin
        c_we = bus.rf_we;
        c_w  = {bus.rf_rd, bus.rf_wdata};
        #1;
        if (c_we) begin
            if (wq.size() == 0) fail("unexpected_write");
            else chk("write", 64'(c_w), 64'(wq.pop_front()));
        end
    end

    // Output monitor: per-cycle ownership outputs and grant-change events against the model
    always @(negedge clk) begin
        exp_g = m_owner < 0 ? '0 : NUM_REQ'(1) << m_owner;
        chk("grant", 64'(bus.grant), 64'(exp_g));
        chk("busy", 64'(bus.busy), 64'(m_owner >= 0));
        if (m_owner >= 0) begin
            chk("owner_id", 64'(bus.owner_id), 64'(m_owner));
            chk("rf_we", 64'(bus.rf_we), 64'(bus.req[m_owner] & bus.req_we[m_owner]));
            chk("rf_rs1", 64'(bus.rf_rs1), 64'(bus.req_rs1[m_owner*ADDR_W +: ADDR_W]));
            chk("rdata1", 64'(bus.rdata1), 64'(regs[bus.req_rs1[m_owner*ADDR_W +: ADDR_W]]));
            chk("rdata2", 64'(bus.rdata2), 64'(regs[bus.req_rs2[m_owner*ADDR_W +: ADDR_W]]));
        end else begin
            chk("idle_rf", 64'({bus.rf_we, bus.rf_rd, bus.rf_wdata}), 64'(0));
        end
        if (bus.grant != prev_g && bus.grant != '0) begin
            if (gq.size() == 0) fail("unexpected_grant_event");
            else begin
                e = gq.pop_front();
                chk("grant_event", 64'(bus.owner_id), 64'(e));
            end
        end
        prev_g = bus.grant;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.req = '0;
        bus.req_we = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_rd = '0;
        bus.req_wdata = '0;
        step(2);
        rst = 1'b0;
        chk("reset_grant", 64'(bus.grant), 64'(0));
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_owner", 64'(bus.owner_id), 64'(0));
        chk("reset_rf_we", 64'(bus.rf_we), 64'(0));

        bus.req = 4'b0001;
        drive(0, 1'b1, 5'd7, 32'hDEADBEEF);
        step(1);
        chk("first_grant", 64'(bus.grant), 64'(4'b0001));
        chk("first_we", 64'(bus.rf_we), 64'(1));
        step(1);
        chk("reg7", 64'(regs[7]), 64'(32'hDEADBEEF));

        bus.req = 4'b0000;
        drive(0, 1'b1, 5'd9, 32'h12345678);
        #1;
        chk("drop_we_suppressed", 64'(bus.rf_we), 64'(0));
        step(1);
        chk("reg9_unchanged", 64'(regs[9]), 64'(0));

        bus.req = 4'b0001;
        step(1);
        bus.req = 4'b0101;
        step(1);
        bus.req = 4'b0100;
        step(1);
        chk("handoff_grant", 64'(bus.grant), 64'(4'b0100));
        chk("handoff_busy", 64'(bus.busy), 64'(1));
        bus.req = 4'b0000;
        step(1);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("rotation", 64'(bus.grant), 64'(4'b0001 << ((c / MAX_HOLD) % NUM_REQ)));
        end

        bus.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("lock_single", 64'(bus.grant), 64'(4'b0010));
        end

        bus.req = 4'b0100;
        drive(2, 1'b1, 5'd3, 32'hA5A5_0001);
        step(1);
        chk("owner2_grant", 64'(bus.grant), 64'(4'b0100));
        step(1);
        drive(2, 1'b1, 5'd4, 32'hA5A5_0002);
        step(1);
        drive(2, 1'b1, 5'd5, 32'hA5A5_0003);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_grant", 64'(bus.grant), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        bus.req = 4'b1111;
        step(1);
        chk("post_rst_pick0", 64'(bus.grant), 64'(4'b0001));
        bus.req = 4'b0000;
        step(1);

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        bus.req[i] = 1'b1;
                        len[i] = $urandom_range(1, 8);
                    end
                end else begin
                    len[i] = len[i] - 1;
                    if (len[i] <= 0) bus.req[i] = 1'b0;
                end
            end
            bus.req_we    = NUM_REQ'($urandom);
            bus.req_rs1   = (NUM_REQ*ADDR_W)'($urandom);
            bus.req_rs2   = (NUM_REQ*ADDR_W)'($urandom);
            bus.req_rd    = (NUM_REQ*ADDR_W)'($urandom);
            bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(99) == 0);
            step(1);
        end

        rst = 1'b0;
        bus.req = '0;
        step(3);
        chk("write_queue_drained", 64'(wq.size()), 64'(0));
        chk("grant_queue_drained", 64'(gq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
